// File: rtl/a_master_requester.sv
// Bus-master requester: serialises a slave-ID request to the bus controller and tracks grant/preempt frames.
// Optional grant-wait timeout is built when A_MASTER_REQUESTER_TIMEOUT_EN is defined.
module a_master_requester #(
  parameter int NO_SLAVES  = 3,
  parameter int S_ID_WIDTH = $clog2(NO_SLAVES + 1),
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [S_ID_WIDTH-1:0] slave_id,
  input  logic                  done,
  output logic                  ready,
  output logic                  granted,
  output logic                  preempted,
  output logic                  timeout,
  output logic                  arb_req,
  input  logic                  arb_grant
);

  localparam int              CNT_W    = $clog2(S_ID_WIDTH + 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(S_ID_WIDTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_ID,
    ST_WAIT_GRANT,
    ST_GRANTED,
    ST_PREEMPTED
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [S_ID_WIDTH-1:0] r_id_sr;
  logic [1:0]            r_dec_cnt;
  logic                  r_dec_msb;
  logic                  w_accept;
  logic                  w_dec_en;
  logic                  w_frame_done;
  logic                  w_grant_rx;
  logic                  w_stop_rx;
  logic                  w_timeout_hit;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("a_master_requester: TIMEOUT must be at least 1");
  end

  assign w_accept     = (r_state == ST_IDLE) && req && (slave_id != '0);
  assign w_dec_en     = (r_state == ST_WAIT_GRANT) || (r_state == ST_GRANTED) ||
                        (r_state == ST_PREEMPTED);
  assign w_frame_done = w_dec_en && (r_dec_cnt == 2'd2);
  assign w_grant_rx   = w_frame_done && r_dec_msb && arb_grant;
  assign w_stop_rx    = w_frame_done && r_dec_msb && !arb_grant;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // ID shifter: start bit on count 0, then one ID bit per cycle, MSB first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt <= '0;
      r_id_sr   <= '0;
    end else begin
      if (w_accept)
        r_id_sr <= slave_id;
      else if ((r_state == ST_SEND_ID) && (r_bit_cnt != '0))
        r_id_sr <= r_id_sr << 1;

      if ((r_state == ST_SEND_ID) && (r_bit_cnt != BIT_LAST))
        r_bit_cnt <= r_bit_cnt + 1'b1;
      else
        r_bit_cnt <= '0;
    end
  end

  // Controller frame decoder: hunt for start bit, capture code MSB, complete on code LSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dec_cnt <= 2'd0;
      r_dec_msb <= 1'b0;
    end else if (!w_dec_en) begin
      r_dec_cnt <= 2'd0;
      r_dec_msb <= 1'b0;
    end else begin
      case (r_dec_cnt)
        2'd0: if (arb_grant) r_dec_cnt <= 2'd1;
        2'd1: begin
          r_dec_msb <= arb_grant;
          r_dec_cnt <= 2'd2;
        end
        default: r_dec_cnt <= 2'd0;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    ready        = 1'b0;
    granted      = 1'b0;
    preempted    = 1'b0;
    arb_req      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        ready   = 1'b1;
        arb_req = 1'b0;
        if (w_accept) w_state_next = ST_SEND_ID;
      end
      ST_SEND_ID: begin
        arb_req = (r_bit_cnt == '0) ? 1'b1 : r_id_sr[S_ID_WIDTH-1];
        if (r_bit_cnt == BIT_LAST) w_state_next = ST_WAIT_GRANT;
      end
      ST_WAIT_GRANT: begin
        if (done)               w_state_next = ST_IDLE;
        else if (w_grant_rx)    w_state_next = ST_GRANTED;
        else if (w_timeout_hit) w_state_next = ST_IDLE;
      end
      ST_GRANTED: begin
        granted = 1'b1;
        if (done)           w_state_next = ST_IDLE;
        else if (w_stop_rx) w_state_next = ST_PREEMPTED;
      end
      ST_PREEMPTED: begin
        preempted = 1'b1;
        if (done)            w_state_next = ST_IDLE;
        else if (w_grant_rx) w_state_next = ST_GRANTED;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

`ifdef A_MASTER_REQUESTER_TIMEOUT_EN
  localparam int              TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] r_wait_cnt;
  logic            r_timeout;

  assign w_timeout_hit = (r_state == ST_WAIT_GRANT) && (r_wait_cnt == TO_LAST);

  // Counter restarts whenever WAIT_GRANT is entered; done or a grant override the timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= w_timeout_hit && !done && !w_grant_rx;
      if ((r_state == ST_WAIT_GRANT) && (w_state_next == ST_WAIT_GRANT))
        r_wait_cnt <= r_wait_cnt + 1'b1;
      else
        r_wait_cnt <= '0;
    end
  end

  assign timeout = r_timeout;
`else
  assign w_timeout_hit = 1'b0;
  assign timeout       = 1'b0;
`endif

endmodule

// File: tb/tb_a_master_requester.sv
// Scoreboard bench for a_master_requester: a transaction-level model predicts every cycle's outputs,
// a negedge monitor compares them; directed scenarios precede a randomized run.
module tb_a_master_requester;

  localparam int SW  = 2;
  localparam int TMO = 8;
`ifdef A_MASTER_REQUESTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic [SW-1:0] slave_id;
  logic          done;
  logic          ready;
  logic          granted;
  logic          preempted;
  logic          timeout;
  logic          arb_req;
  logic          arb_grant;

  always #5 clk = ~clk;

  a_master_requester #(
    .NO_SLAVES (3),
    .TIMEOUT   (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .slave_id  (slave_id),
    .done      (done),
    .ready     (ready),
    .granted   (granted),
    .preempted (preempted),
    .timeout   (timeout),
    .arb_req   (arb_req),
    .arb_grant (arb_grant)
  );

  typedef struct packed {
    logic ready;
    logic granted;
    logic preempted;
    logic timeout;
    logic arb_req;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic act, input logic exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp_v, $time);
    end
  endtask

  // Reference model: ownership phase, queue of bits still to serialise, queue of received frame bits.
  typedef enum int {M_IDLE, M_SEND, M_WAIT, M_OWN, M_SUSP} mphase_t;
  mphase_t m_phase;
  bit      m_tx[$];
  bit      m_rx[$];
  int      m_wait;
  bit      m_to;

  function automatic exp_t model_out();
    exp_t e;
    e.ready     = (m_phase == M_IDLE);
    e.granted   = (m_phase == M_OWN);
    e.preempted = (m_phase == M_SUSP);
    e.timeout   = m_to;
    if (m_phase == M_IDLE)      e.arb_req = 1'b0;
    else if (m_phase == M_SEND) e.arb_req = m_tx[0];
    else                        e.arb_req = 1'b1;
    return e;
  endfunction

  task automatic model_reset();
    m_phase = M_IDLE;
    m_tx.delete();
    m_rx.delete();
    m_wait = 0;
    m_to   = 1'b0;
  endtask

  task automatic model_step(input bit r, input bit [SW-1:0] sid, input bit d, input bit g);
    int ev;
    bit to_next;
    ev      = 0;
    to_next = 1'b0;
    case (m_phase)
      M_IDLE: begin
        if (r && sid != 0) begin
          m_tx.delete();
          m_tx.push_back(1'b1);
          for (int i = SW - 1; i >= 0; i--) m_tx.push_back(sid[i]);
          m_phase = M_SEND;
        end
      end
      M_SEND: begin
        void'(m_tx.pop_front());
        if (m_tx.size() == 0) begin
          m_phase = M_WAIT;
          m_wait  = 0;
          m_rx.delete();
        end
      end
      default: begin
        if (m_rx.size() != 0 || g) m_rx.push_back(g);
        if (m_rx.size() == 3) begin
          if (m_rx[1] && m_rx[2])       ev = 1;
          else if (m_rx[1] && !m_rx[2]) ev = 2;
          m_rx.delete();
        end
        if (d) begin
          m_phase = M_IDLE;
          m_rx.delete();
        end else if (ev == 1 && m_phase != M_OWN) begin
          m_phase = M_OWN;
        end else if (ev == 2 && m_phase == M_OWN) begin
          m_phase = M_SUSP;
        end else if (m_phase == M_WAIT) begin
          m_wait++;
          if (TO_EN && m_wait == TMO) begin
            m_phase = M_IDLE;
            m_rx.delete();
            to_next = 1'b1;
          end
        end
      end
    endcase
    m_to = to_next;
  endtask

  // One clock cycle: record this cycle's expectation, then drive inputs and advance the model.
  task automatic step(input bit r_rst, input bit r, input bit [SW-1:0] sid, input bit d, input bit g);
    @(posedge clk);
    #1;
    exp_q.push_back(model_out());
    rst       = r_rst;
    req       = r;
    slave_id  = sid;
    done      = d;
    arb_grant = g;
    if (r_rst) model_reset();
    else       model_step(r, sid, d, g);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic frame(input bit b1, input bit b0, input bit last_done);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, b1);
    step(1'b0, 1'b0, '0, last_done, b0);
  endtask

  // Asserts reset between edges, after this cycle was sampled, and checks outputs drop at once.
  task automatic reset_mid_op();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_granted", granted, 1'b0);
    check("async_arb_req", arb_req, 1'b0);
    check("async_ready", ready, 1'b1);
    model_reset();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ready", ready, e.ready);
        check("granted", granted, e.granted);
        check("preempted", preempted, e.preempted);
        check("timeout", timeout, e.timeout);
        check("arb_req", arb_req, e.arb_req);
      end
    end
  end

  initial begin : stimulus
    bit            gq[$];
    bit            g;
    bit [SW-1:0]   rsid;
    int            gprob;
    int            kind;
    rst       = 1'b1;
    req       = 1'b0;
    slave_id  = '0;
    done      = 1'b0;
    arb_grant = 1'b0;
    model_reset();

    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    idle(2);

    // Request to slave 0 is ignored.
    step(1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
    idle(2);

    // Basic request to slave 2, done during the ID frame, then grant / stop / grant.
    step(1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    idle(3);
    frame(1'b1, 1'b1, 1'b0);
    idle(2);
    frame(1'b1, 1'b0, 1'b0);
    idle(2);
    frame(1'b1, 1'b1, 1'b0);
    idle(2);

    // Reset while granted, then a clean new request.
    reset_mid_op();
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
    idle(4);

    // Done in the same cycle the grant frame completes.
    frame(1'b1, 1'b1, 1'b1);
    idle(2);

    // Grant never comes: timeout when built in, otherwise keep waiting until done.
    step(1'b0, 1'b1, 2'b11, 1'b0, 1'b0);
    idle(16);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    idle(2);

    for (int blk = 0; blk < 8; blk++) begin
      gprob = (blk % 3 == 2) ? 0 : 4;
      for (int c = 0; c < 400; c++) begin
        if (gq.size() == 0 && gprob != 0 && $urandom_range(gprob - 1) == 0) begin
          kind = int'($urandom_range(3));
          gq.push_back(1'b1);
          if (kind <= 1) begin
            gq.push_back(1'b1);
            gq.push_back(1'b1);
          end else if (kind == 2) begin
            gq.push_back(1'b1);
            gq.push_back(1'b0);
          end else begin
            gq.push_back(1'b0);
            gq.push_back(1'($urandom_range(1)));
          end
        end
        g    = (gq.size() != 0) ? gq.pop_front() : 1'b0;
        rsid = SW'($urandom_range(3));
        step(1'b0, $urandom_range(2) == 0, rsid, $urandom_range(23) == 0, g);
      end
    end

    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size() == 0, 1'b1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/a_master_requester.md
A_MASTER_REQUESTER -- requirements
Module: a_master_requester

Interface
- REQ-001 SHALL have parameter NO_SLAVES, default 3: number of slaves on the bus.
- REQ-002 SHALL have parameter S_ID_WIDTH, default $clog2(NO_SLAVES+1): slave-ID width; ID 0 means "no request".
- REQ-003 SHALL have parameter TIMEOUT, default 64: grant-wait limit in cycles; used only under REQ-033.
- REQ-004 SHALL have port clk, input, 1, the single clock; every register is rising-edge.
- REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
- REQ-006 SHALL have port req, input, 1, user request strobe.
- REQ-007 SHALL have port slave_id, input, S_ID_WIDTH, target slave, sampled when the request is accepted.
- REQ-008 SHALL have port done, input, 1, user release or cancel.
- REQ-009 SHALL have port ready, output, 1, idle and able to accept a request.
- REQ-010 SHALL have port granted, output, 1, bus currently owned.
- REQ-011 SHALL have port preempted, output, 1, ownership suspended by the controller.
- REQ-012 SHALL have port timeout, output, 1, one-cycle grant-timeout pulse.
- REQ-013 SHALL have port arb_req, output, 1, serial line to the bus controller.
- REQ-014 SHALL have port arb_grant, input, 1, serial line from the bus controller.

Function
- REQ-015 SHALL implement states IDLE, SEND_ID, WAIT_GRANT, GRANTED and PREEMPTED.
- REQ-016 SHALL accept a request when ready=1, req=1 and slave_id!=0, latching slave_id and entering SEND_ID on the next edge.
- REQ-017 SHALL ignore req when slave_id==0 or ready=0; ready and all other outputs stay unchanged.
- REQ-018 SHALL assert ready only in IDLE.
- REQ-019 SHALL drive arb_req=0 in IDLE.
- REQ-020 SHALL, in SEND_ID, drive arb_req=1 (start bit) on the first cycle, then the latched ID MSB-first over the next S_ID_WIDTH cycles, then enter WAIT_GRANT.
- REQ-021 SHALL hold arb_req=1 in WAIT_GRANT, GRANTED and PREEMPTED.
- REQ-022 SHALL decode controller frames on arb_grant as 3 bits: start bit 1, then a 2-bit code, MSB first.
- REQ-023 SHALL treat code 2'b11 as GRANT and code 2'b10 as STOP; all other codes are discarded.
- REQ-024 SHALL enable the frame decoder only in WAIT_GRANT, GRANTED and PREEMPTED; it is cleared in every other state.
- REQ-025 SHALL, on a GRANT completed in WAIT_GRANT or PREEMPTED, enter GRANTED; granted=1 from the next cycle and preempted=0.
- REQ-026 SHALL, on a STOP completed in GRANTED, enter PREEMPTED; granted=0 and preempted=1 from the next cycle.
- REQ-027 SHALL ignore a GRANT while in GRANTED and a STOP while in WAIT_GRANT or PREEMPTED.
- REQ-028 SHALL, on done=1 in WAIT_GRANT, GRANTED or PREEMPTED, enter IDLE next cycle: arb_req=0, granted=0, preempted=0, ready=1.
- REQ-029 SHALL let done win when done and a frame completion occur in the same cycle.
- REQ-030 SHALL ignore done in IDLE and SEND_ID; the ID frame always completes.

Reset
- REQ-031 SHALL, while rst=1, immediately force state IDLE, ready=1, granted=0, preempted=0, timeout=0 and arb_req=0, and clear the decoder, bit counter, latched ID and timeout counter.
- REQ-032 SHALL abandon any frame that is in progress when reset is asserted mid-operation, with no partial resume after reset.

Configuration
- REQ-033 SHALL, with macro A_MASTER_REQUESTER_TIMEOUT_EN defined, count cycles spent in WAIT_GRANT; when the count reaches TIMEOUT it pulses timeout for one cycle and enters IDLE with arb_req=0.
- REQ-034 SHALL, without A_MASTER_REQUESTER_TIMEOUT_EN, wait in WAIT_GRANT indefinitely, tie timeout to 0 and contain no counter logic.
- REQ-035 SHALL reset the timeout counter on every entry to WAIT_GRANT; PREEMPTED is never timed.

Verification (NO_SLAVES=3, S_ID_WIDTH=2)
- REQ-036 SHALL cover a basic request: req with slave_id=2'b10 at cycle 0 -> arb_req 1,1,0 in cycles 1-3, then held at 1; ready=0 from cycle 1; GRANT frame 1,1,1 on arb_grant -> granted=1 the cycle after the last bit.
- REQ-037 SHALL cover preemption: GRANT, then STOP frame 1,1,0 -> granted=0 and preempted=1; a second GRANT -> granted=1 and preempted=0; arb_req stays 1 throughout.
- REQ-038 SHALL cover a same-cycle collision: done=1 in the cycle the GRANT frame completes -> IDLE, granted never asserts, arb_req=0 and ready=1 next cycle.
- REQ-039 SHALL cover invalid and mid-frame requests: req with slave_id=0 -> no arb_req activity, ready stays 1; done during SEND_ID -> ID frame completes unchanged.
- REQ-040 SHALL cover timeout with A_MASTER_REQUESTER_TIMEOUT_EN defined and TIMEOUT=8: no grant -> timeout pulse 8 cycles after WAIT_GRANT entry, then arb_req=0 and ready=1; without the macro, timeout stays 0 for 100 cycles.
- REQ-041 SHALL cover reset mid-operation: rst=1 in GRANTED -> granted=0 and arb_req=0 asynchronously; after release a new request starts a clean frame.
